// File: rtl/dcsk_burst_tx_pkg.sv
// Shared constants and helpers for the DCSK burst transmitter.
// Spreading factor is 4 << select; FSM encodings are kept as plain constants.
package dcsk_burst_tx_pkg;

   localparam int SF_MIN_LOG2 = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REF  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   function automatic int sf_chips(input int sel);
      return 4 << sel;
   endfunction

   // Compare before shifting so oversized selects cannot overflow the int.
   function automatic int clamp_chips(input int sel, input int max_log2);
      if (sel + SF_MIN_LOG2 > max_log2) return 1 << max_log2;
      return sf_chips(sel);
   endfunction

endpackage

// File: rtl/dcsk_burst_tx_if.sv
// Word/spreading-factor push interface into the DCSK transmitter queue.
interface dcsk_burst_tx_if #(
   parameter int MSG_W    = 32,
   parameter int SF_SEL_W = 2
);
   logic [MSG_W-1:0]    i_msg;
   logic [SF_SEL_W-1:0] i_sf;
   logic                i_valid;
   logic                o_ready;

   modport master (output i_msg, output i_sf, output i_valid, input o_ready);
   modport slave  (input i_msg, input i_sf, input i_valid, output o_ready);
endinterface

// File: rtl/dcsk_burst_tx_chaos_lfsr.sv
// Seedable Galois LFSR used as the chaotic reference chip source.
module chaos_lfsr #(
   parameter int                LFSR_W = 16,
   parameter logic [LFSR_W-1:0] POLY   = 16'hB400
) (
   input  logic              i_clk,
   input  logic              i_arst_n,
   input  logic              i_load,
   input  logic [LFSR_W-1:0] i_seed,
   input  logic              i_step,
   output logic              o_out
);

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      lfsr_d = lfsr_q;
      if (i_load) begin
         // An all-zero state would lock the generator up for good.
         lfsr_d = (i_seed == '0) ? LFSR_W'(1) : i_seed;
      end else if (i_step) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) lfsr_q <= LFSR_W'(1);
      else           lfsr_q <= lfsr_d;
   end

   assign o_out = lfsr_q[0];

endmodule

// File: rtl/dcsk_burst_tx.sv
// DCSK burst transmitter: queues (word, SF) pairs and serialises them MSB-first
// as reference/data chip halves, gap-free while the queue holds words.
module dcsk_burst_tx
   import dcsk_burst_tx_pkg::*;
#(
   parameter int                MSG_W       = 32,
   parameter int                SF_SEL_W    = 2,
   parameter int                MAX_SF_LOG2 = 5,
   parameter int                LFSR_W      = 16,
   parameter logic [LFSR_W-1:0] POLY        = 16'hB400,
   parameter int                FIFO_DEPTH  = 4
) (
   input  logic                        i_clk,
   input  logic                        i_arst_n,
   input  logic [LFSR_W-1:0]           i_seed,
   input  logic                        i_load_seed,
   dcsk_burst_tx_if.slave              bus,
   output logic                        o_tx,
   output logic                        o_is_sending,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
   output logic                        o_seed_rejected
);

   localparam int CW    = MAX_SF_LOG2 - 1;
   localparam int REF_W = 1 << CW;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int BIT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
   localparam int ENT_W = SF_SEL_W + MSG_W;

   // Last chip index of one half-bit (H-1) for a given select, after clamping.
   function automatic logic [CW-1:0] half_last(input logic [SF_SEL_W-1:0] sel);
      return CW'(clamp_chips(int'(sel), MAX_SF_LOG2) / 2 - 1);
   endfunction

   logic [1:0]          rst_sync_q, rst_sync_d;
   logic                arst_n_sync;
   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       chip_q, chip_d, last_q, last_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [MSG_W-1:0]    msg_q, msg_d;
   logic [REF_W-1:0]    ref_q, ref_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                seed_rej_q, seed_rej_d;
   logic [ENT_W-1:0]    fifo_mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]    head;
   logic                do_push, do_pop, fifo_empty, word_done, load_ok, lfsr_out;

   // Reset asserts immediately but releases on a clock edge.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) rst_sync_q <= '0;
      else           rst_sync_q <= rst_sync_d;
   end
   assign arst_n_sync = rst_sync_q[1];

   always_comb begin
      bus.o_ready = (level_q != LVL_W'(FIFO_DEPTH));
      fifo_empty  = (level_q == '0);
      do_push     = bus.i_valid && bus.o_ready;
      word_done   = (state_q == ST_DATA) && (chip_q == last_q) && (bit_q == BIT_W'(MSG_W - 1));
      do_pop      = !fifo_empty && ((state_q == ST_IDLE) || word_done);
      head        = fifo_mem_q[rd_ptr_q];
      wr_ptr_d    = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d    = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d     = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
      load_ok     = i_load_seed && (state_q == ST_IDLE) && fifo_empty;
      seed_rej_d  = i_load_seed && !load_ok;
   end

   // NOTE: queue storage has no reset; the level and pointers alone define what is valid.
   always_ff @(posedge i_clk) begin
      if (do_push) fifo_mem_q[wr_ptr_q] <= {bus.i_sf, bus.i_msg};
   end

   always_comb begin
      state_d = state_q;
      chip_d  = chip_q;
      bit_d   = bit_q;
      last_d  = last_q;
      msg_d   = msg_q;
      ref_d   = ref_q;
      case (state_q)
         ST_IDLE: ;
         ST_REF: begin
            ref_d[chip_q] = lfsr_out;
            if (chip_q == last_q) begin
               chip_d  = '0;
               state_d = ST_DATA;
            end else begin
               chip_d = chip_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (chip_q != last_q) begin
               chip_d = chip_q + CW'(1);
            end else begin
               chip_d = '0;
               if (bit_q == BIT_W'(MSG_W - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  msg_d   = msg_q << 1;
                  state_d = ST_REF;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A pop overrides the end-of-word return to IDLE, keeping the burst gap-free.
      if (do_pop) begin
         state_d = ST_REF;
         chip_d  = '0;
         bit_d   = '0;
         msg_d   = head[MSG_W-1:0];
         last_d  = half_last(head[ENT_W-1 -: SF_SEL_W]);
      end
   end

   always_ff @(posedge i_clk or negedge arst_n_sync) begin
      if (!arst_n_sync) begin
         state_q    <= ST_IDLE;
         chip_q     <= '0;
         bit_q      <= '0;
         last_q     <= '0;
         msg_q      <= '0;
         ref_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         seed_rej_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         chip_q     <= chip_d;
         bit_q      <= bit_d;
         last_q     <= last_d;
         msg_q      <= msg_d;
         ref_q      <= ref_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         seed_rej_q <= seed_rej_d;
      end
   end

   chaos_lfsr #(.LFSR_W(LFSR_W), .POLY(POLY)) u_lfsr (
      .i_clk    (i_clk),
      .i_arst_n (arst_n_sync),
      .i_load   (load_ok),
      .i_seed   (i_seed),
      .i_step   (state_q == ST_REF),
      .o_out    (lfsr_out)
   );

   // Bit 1 repeats the stored reference, bit 0 inverts it.
   always_comb begin
      case (state_q)
         ST_REF:  o_tx = lfsr_out;
         ST_DATA: o_tx = ref_q[chip_q] ^ ~msg_q[MSG_W-1];
         default: o_tx = 1'b0;
      endcase
   end

   assign o_is_sending    = (state_q != ST_IDLE);
   assign o_fifo_level    = level_q;
   assign o_seed_rejected = seed_rej_q;

endmodule
